dmem_responder: RTL and testbench

- Data-memory responder: the far end of the MEM-stage load/store interface driven by the pipelined cpu.
- Accepts one read or write request at a time and performs it after a fixed, parameterised latency.
- Holds the pipeline with stall while an access is in flight.
- Returns load data on ldata, and pulses done for the single cycle in which the pipeline is released.

---
 rtl/dmem_responder.sv | 91 +++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// Serves one load or store at a time after LAT cycles and stalls the pipeline meanwhile.
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [15:0] addr,
  input  logic [15:0] sdata,
  output logic [15:0] ldata,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]        cnt;
  logic [ADDR_W-1:0] a_q;
  logic [15:0]       d_q;
  logic              wr_q;
  logic              req;
  logic              commit;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  assign req    = re_mem | we_mem;
  assign commit = (state == S_BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (req) state_nx = S_BUSY;
      S_BUSY:  if (cnt == 4'd0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    unique case (state)
      S_IDLE:  stall = req;
      S_BUSY:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Request is latched on accept; inputs are ignored while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 4'd0;
      a_q   <= '0;
      d_q   <= 16'h0000;
      wr_q  <= 1'b0;
      ldata <= 16'h0000;
      done  <= 1'b0;
    end else begin
      done <= commit;
      if (state == S_IDLE && req) begin
        a_q  <= addr[ADDR_W-1:0];
        d_q  <= sdata;
        wr_q <= we_mem;
        cnt  <= 4'(LAT - 1);
      end else if (state == S_BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !wr_q) ldata <= mem[a_q];
    end
  end

  // Storage is never reset; a reset forces IDLE so no commit can fire.
  always_ff @(posedge clk) begin
    if (commit && wr_q) mem[a_q] <= d_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// A plain word-array model predicts every load and the stall/done timeline.
module tb_dmem_responder;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        re_mem, we_mem;
  logic [15:0] addr, sdata;
  logic [15:0] ldata;
  logic        stall, done;

  logic        re1, we1, re15, we15;
  logic [15:0] ldata1, ldata15;
  logic        stall1, done1, stall15, done15;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [0:(1<<AW)-1];
  logic [15:0] ld_m;

  dmem_responder #(.ADDR_W(AW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .re_mem(re_mem), .we_mem(we_mem),
    .addr(addr), .sdata(sdata), .ldata(ldata), .stall(stall), .done(done)
  );

  dmem_responder #(.ADDR_W(AW), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .re_mem(re1), .we_mem(we1),
    .addr(addr), .sdata(sdata), .ldata(ldata1), .stall(stall1), .done(done1)
  );

  dmem_responder #(.ADDR_W(AW), .LAT(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .re_mem(re15), .we_mem(we15),
    .addr(addr), .sdata(sdata), .ldata(ldata15), .stall(stall15), .done(done15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access on the LAT=3 dut; requests stay high through the done cycle.
  task automatic access(input string nm, input bit r, input bit w,
                        input logic [15:0] a, input logic [15:0] d,
                        input bit wig, input logic [15:0] a2,
                        input logic [15:0] d2);
    logic [AW-1:0] idx;
    @(posedge clk); #1;
    re_mem = r; we_mem = w; addr = a; sdata = d;
    idx = a[AW-1:0];
    if (w) mem_m[idx] = d;
    else   ld_m = mem_m[idx];
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc%0d: stall=%b done=%b, expected stall=1 done=0",
                 nm, c, stall, done);
      end
      @(posedge clk); #1;
      if (wig) begin addr = a2; sdata = d2; end
    end
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || done !== 1'b1 || ldata !== ld_m) begin
      errors++;
      $display("FAIL %s done-cycle: stall=%b done=%b ldata=%h, expected 0 1 %h",
               nm, stall, done, ldata, ld_m);
    end
  endtask

  task automatic idle_cycle(input string nm);
    @(posedge clk); #1;
    re_mem = 1'b0; we_mem = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || ldata !== ld_m) begin
      errors++;
      $display("FAIL %s idle: stall=%b done=%b ldata=%h, expected 0 0 %h",
               nm, stall, done, ldata, ld_m);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    re_mem = 0; we_mem = 0; re1 = 0; we1 = 0; re15 = 0; we15 = 0;
    addr = 0; sdata = 0;
    ld_m = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || ldata !== 16'h0000) begin
      errors++;
      $display("FAIL reset: stall=%b done=%b ldata=%h, expected 0 0 0000",
               stall, done, ldata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    access("wr_beef", 0, 1, 16'h0010, 16'hBEEF, 0, 0, 0);
    access("rd_beef", 1, 0, 16'h0010, 16'h0000, 0, 0, 0);
    idle_cycle("wr_rd");
  endtask

  task automatic test_both_high;
    access("both", 1, 1, 16'h0005, 16'h1234, 0, 0, 0);
    checks++;
    if (ldata !== 16'hBEEF) begin
      errors++;
      $display("FAIL both_keep: ldata=%h, expected beef", ldata);
    end
    access("rd_5", 1, 0, 16'h0005, 16'h0000, 0, 0, 0);
    idle_cycle("both");
  endtask

  task automatic test_busy_change;
    access("pre_7", 0, 1, 16'h0007, 16'h7777, 0, 0, 0);
    access("wig", 0, 1, 16'h0003, 16'hAAAA, 1, 16'h0007, 16'h5555);
    access("rd_3", 1, 0, 16'h0003, 16'h0000, 0, 0, 0);
    access("rd_7", 1, 0, 16'h0007, 16'h0000, 0, 0, 0);
    idle_cycle("wig");
  endtask

  task automatic test_reset_busy;
    access("pre_9", 0, 1, 16'h0009, 16'h1111, 0, 0, 0);
    @(posedge clk); #1;
    we_mem = 1'b1; re_mem = 1'b0; addr = 16'h0009; sdata = 16'hCAFE;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    ld_m = 16'h0000;
    #1;
    checks++;
    if (ldata !== 16'h0000 || done !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy: ldata=%h done=%b stall=%b, expected 0000 0 1",
               ldata, done, stall);
    end
    we_mem = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: stall=%b, expected 0", stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access("rd_9", 1, 0, 16'h0009, 16'h0000, 0, 0, 0);
    idle_cycle("rst_busy");
  endtask

  task automatic test_alias;
    access("al_wr", 0, 1, 16'h0402, 16'h0F0F, 0, 0, 0);
    access("al_rd", 1, 0, 16'h0002, 16'h0000, 0, 0, 0);
    idle_cycle("alias");
  endtask

  task automatic test_back_to_back;
    logic [9:0]  pool [8];
    logic [15:0] a;
    bit          r, w;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 10'($urandom_range(16, 1023));
      access("b2b_init", 0, 1, {6'h00, pool[i]}, 16'($urandom), 0, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      a = {6'($urandom), pool[$urandom_range(0, 7)]};
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      access("b2b", r, w, a, 16'($urandom), 1'($urandom),
             16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle("b2b");
    end
    idle_cycle("b2b_end");
  endtask

  task automatic sweep_one(input int lat, input bit w,
                           input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] exp_ld);
    int width;
    logic st, dn;
    logic [15:0] ld;
    @(posedge clk); #1;
    addr = a; sdata = d;
    if (lat == 15) begin re15 = ~w; we15 = w; end
    else           begin re1 = ~w;  we1 = w;  end
    width = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      st = (lat == 15) ? stall15 : stall1;
      if (st) width++;
      else break;
    end
    dn = (lat == 15) ? done15 : done1;
    ld = (lat == 15) ? ldata15 : ldata1;
    checks++;
    if (width != lat + 1 || dn !== 1'b1 || ld !== exp_ld) begin
      errors++;
      $display("FAIL sweep_lat%0d: width=%0d done=%b ldata=%h, expected %0d 1 %h",
               lat, width, dn, ld, lat + 1, exp_ld);
    end
    @(posedge clk); #1;
    re1 = 0; we1 = 0; re15 = 0; we15 = 0;
    @(negedge clk);
    dn = (lat == 15) ? done15 : done1;
    st = (lat == 15) ? stall15 : stall1;
    checks++;
    if (dn !== 1'b0 || st !== 1'b0) begin
      errors++;
      $display("FAIL sweep_after_lat%0d: done=%b stall=%b, expected 0 0",
               lat, dn, st);
    end
  endtask

  task automatic test_latency_sweep;
    logic [15:0] d1, d15;
    d1  = 16'($urandom);
    d15 = 16'($urandom);
    sweep_one(1, 1, 16'h0021, d1, 16'h0000);
    sweep_one(1, 0, 16'h0021, 16'h0000, d1);
    sweep_one(15, 1, 16'h0022, d15, 16'h0000);
    sweep_one(15, 0, 16'h0022, 16'h0000, d15);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_both_high();
    test_busy_change();
    test_reset_busy();
    test_alias();
    test_back_to_back();
    test_latency_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
